// File: rtl/avalon_dma_master.sv
// avalon_dma_master: single-channel word copy engine with an Avalon
// slave for configuration and an Avalon master for SRC->DST moves.
module avalon_dma_master #(
  parameter int ADDR_SEL_BITS = 0,
  parameter int ADDR_BLOCK    = 0,
  parameter int READ_LATENCY  = 1,
  parameter int LEN_BITS      = 16
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic                      i_AV_SlaveSel,
  input  logic [29-ADDR_SEL_BITS:0] i_AV_RegAddr,
  input  logic [3:0]                i_AV_ByteEn,
  input  logic                      i_AV_Read,
  input  logic                      i_AV_Write,
  output logic [31:0]               o_AV_ReadData,
  input  logic [31:0]               i_AV_WriteData,
  output logic                      o_AV_WaitRequest,
  output logic [31:0]               o_AVM_Address,
  output logic [3:0]                o_AVM_ByteEn,
  output logic                      o_AVM_Read,
  output logic                      o_AVM_Write,
  output logic [31:0]               o_AVM_WriteData,
  input  logic [31:0]               i_AVM_ReadData,
  input  logic                      i_AVM_WaitRequest,
  output logic                      o_Irq
);

  localparam int AW = 30 - ADDR_SEL_BITS;

  typedef enum logic [1:0] {
    IDLE, RD, RDW, WR
  } state_t;

  state_t state;

  logic                srcInc;
  logic                dstInc;
  logic                irqEn;
  logic                done;
  logic                abortPend;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LEN_BITS-1:0] len;
  logic [2:0]          latCnt;

  logic        busy;
  logic        rdEn;
  logic        wrEn;
  logic        isCtrl;
  logic        isSrc;
  logic        isDst;
  logic        isLen;
  logic        ctrlWr;
  logic        startReq;
  logic        abortReq;
  logic        doneClr;
  logic [31:0] lenExt;
  logic [31:0] ctrlRd;
  logic [31:0] rdMux;

  // ADDR_BLOCK only matters to the system-level address decoder
  logic unusedBlk;
  assign unusedBlk = ^32'(ADDR_BLOCK);

  function automatic logic [31:0] mergeBytes(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  assign busy   = (state != IDLE);
  assign rdEn   = i_AV_SlaveSel & i_AV_Read;
  assign wrEn   = i_AV_SlaveSel & i_AV_Write;
  assign isCtrl = (i_AV_RegAddr == AW'(0));
  assign isSrc  = (i_AV_RegAddr == AW'(1));
  assign isDst  = (i_AV_RegAddr == AW'(2));
  assign isLen  = (i_AV_RegAddr == AW'(3));

  assign ctrlWr   = wrEn & isCtrl & i_AV_ByteEn[0];
  assign startReq = ctrlWr & i_AV_WriteData[0];
  assign abortReq = ctrlWr & i_AV_WriteData[1];
  assign doneClr  = ctrlWr & i_AV_WriteData[2];

  assign lenExt = 32'(len);
  assign ctrlRd = {25'd0, irqEn, dstInc, srcInc,
                   busy, done, 2'b00};

  always_comb begin
    rdMux = '0;
    unique case (1'b1)
      isCtrl:  rdMux = ctrlRd;
      isSrc:   rdMux = src;
      isDst:   rdMux = dst;
      isLen:   rdMux = lenExt;
      default: rdMux = '0;
    endcase
  end

  assign o_AV_WaitRequest = 1'b0;
  assign o_Irq            = done & irqEn;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state           <= IDLE;
      srcInc          <= 1'b0;
      dstInc          <= 1'b0;
      irqEn           <= 1'b0;
      done            <= 1'b0;
      abortPend       <= 1'b0;
      src             <= '0;
      dst             <= '0;
      len             <= '0;
      latCnt          <= '0;
      o_AV_ReadData   <= '0;
      o_AVM_Address   <= '0;
      o_AVM_ByteEn    <= '0;
      o_AVM_Read      <= 1'b0;
      o_AVM_Write     <= 1'b0;
      o_AVM_WriteData <= '0;
    end else begin
      o_AV_ReadData <= rdEn ? rdMux : '0;

      if (ctrlWr && !busy) begin
        srcInc <= i_AV_WriteData[4];
        dstInc <= i_AV_WriteData[5];
        irqEn  <= i_AV_WriteData[6];
      end
      if (wrEn && isSrc && !busy)
        src <= mergeBytes(src, i_AV_WriteData, i_AV_ByteEn)
               & 32'hFFFF_FFFC;
      if (wrEn && isDst && !busy)
        dst <= mergeBytes(dst, i_AV_WriteData, i_AV_ByteEn)
               & 32'hFFFF_FFFC;
      if (wrEn && isLen && !busy)
        len <= LEN_BITS'(mergeBytes(lenExt, i_AV_WriteData,
                                    i_AV_ByteEn));

      // completion below overrides a same-cycle DONE clear
      if (doneClr) done <= 1'b0;
      if (abortReq && busy) abortPend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (startReq && !abortReq) begin
            if (len == '0) done <= 1'b1;
            else state <= RD;
          end
        end
        RD: begin
          if (!o_AVM_Read) begin
            o_AVM_Read    <= 1'b1;
            o_AVM_ByteEn  <= 4'hF;
            o_AVM_Address <= src;
          end else if (!i_AVM_WaitRequest) begin
            o_AVM_Read   <= 1'b0;
            o_AVM_ByteEn <= 4'h0;
            latCnt       <= 3'd1;
            state        <= RDW;
          end
        end
        RDW: begin
          if (latCnt == 3'(READ_LATENCY)) begin
            o_AVM_Write     <= 1'b1;
            o_AVM_ByteEn    <= 4'hF;
            o_AVM_Address   <= dst;
            o_AVM_WriteData <= i_AVM_ReadData;
            state           <= WR;
          end else begin
            latCnt <= latCnt + 3'd1;
          end
        end
        WR: begin
          if (!i_AVM_WaitRequest) begin
            o_AVM_Write  <= 1'b0;
            o_AVM_ByteEn <= 4'h0;
            len          <= len - LEN_BITS'(1);
            if (srcInc) src <= src + 32'd4;
            if (dstInc) dst <= dst + 32'd4;
            if (len == LEN_BITS'(1) || abortPend) begin
              state     <= IDLE;
              done      <= 1'b1;
              abortPend <= 1'b0;
            end else begin
              state <= RD;
            end
          end
        end
      endcase
    end
  end

endmodule
